// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM pipeline boundary: valid/ready stage with a one-entry skid buffer,
// branch/jump resolution with a one-cycle redirect pulse, flush, and a stall counter.
module ex_mem_pipe_stage #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 14,
   parameter int RD_W   = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [6:0]        in_ctrl,
   input  logic [1:0]        in_bw,
   input  logic              in_branch,
   input  logic              in_zero,
   input  logic              in_jal,
   input  logic              in_jalr,
   input  logic [ADDR_W-1:0] in_pc,
   input  logic [DATA_W-1:0] in_imm,
   input  logic [DATA_W-1:0] in_alu,
   input  logic [DATA_W-1:0] in_wdata,
   input  logic [RD_W-1:0]   in_rd,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [6:0]        out_ctrl,
   output logic [1:0]        out_bw,
   output logic [DATA_W-1:0] out_alu,
   output logic [DATA_W-1:0] out_wdata,
   output logic [RD_W-1:0]   out_rd,
   output logic              redirect,
   output logic [ADDR_W-1:0] redirect_pc,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam int PAY_W = 7 + 2 + DATA_W + DATA_W + RD_W;
   // ctrl bits that cause side effects: reg_we, mem_re, mem_we, io_re, io_we
   localparam logic [6:0] WE_MASK = 7'b1110110;

   logic              r_mainValid;
   logic              r_skidValid;
   logic [PAY_W-1:0]  r_mainPayload;
   logic [PAY_W-1:0]  r_skidPayload;
   logic              r_redirect;
   logic [ADDR_W-1:0] r_redirectPc;
   logic [CNT_W-1:0]  r_stallCnt;

   logic [PAY_W-1:0]  w_inPayload;
   logic              w_accept;
   logic              w_drain;
   logic              w_taken;
   logic [ADDR_W-1:0] w_target;
   logic [6:0]        w_mainCtrl;

   assign w_inPayload = {in_ctrl, in_bw, in_alu, in_wdata, in_rd};
   assign in_ready    = !r_skidValid;
   assign out_valid   = r_mainValid;
   assign w_accept    = in_valid && in_ready && !flush;
   assign w_drain     = r_mainValid && out_ready;
   assign w_taken     = in_jalr || in_jal || (in_branch && in_zero);
   assign w_target    = in_jalr ? {in_alu[ADDR_W-1:1], 1'b0}
                                : (in_pc + in_imm[ADDR_W-1:0]);

   assign {w_mainCtrl, out_bw, out_alu, out_wdata, out_rd} = r_mainPayload;
   assign out_ctrl    = r_mainValid ? w_mainCtrl : (w_mainCtrl & ~WE_MASK);
   assign redirect    = r_redirect;
   assign redirect_pc = r_redirectPc;
   assign stall_cnt   = r_stallCnt;

   // The skid entry is only ever filled while main is full and not draining,
   // so main always holds the oldest op and ordering is preserved.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mainValid   <= 1'b0;
         r_skidValid   <= 1'b0;
         r_mainPayload <= '0;
         r_skidPayload <= '0;
         r_redirect    <= 1'b0;
         r_redirectPc  <= '0;
         r_stallCnt    <= '0;
      end else if (flush) begin
         r_mainValid <= 1'b0;
         r_skidValid <= 1'b0;
         r_redirect  <= 1'b0;
      end else begin
         if (r_mainValid && !out_ready && (r_stallCnt != {CNT_W{1'b1}}))
            r_stallCnt <= r_stallCnt + CNT_W'(1);

         r_redirect <= w_accept && w_taken;
         if (w_accept && w_taken)
            r_redirectPc <= w_target;

         if (!r_mainValid || w_drain) begin
            if (r_skidValid) begin
               r_mainPayload <= r_skidPayload;
               r_mainValid   <= 1'b1;
               r_skidValid   <= 1'b0;
            end else if (w_accept) begin
               r_mainPayload <= w_inPayload;
               r_mainValid   <= 1'b1;
            end else begin
               r_mainValid   <= 1'b0;
            end
         end else if (w_accept) begin
            r_skidPayload <= w_inPayload;
            r_skidValid   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Self-checking bench for ex_mem_pipe_stage: table-driven streaming vectors
// plus directed sequences for back-pressure, redirect, flush, reset and saturation.
module tb_ex_mem_pipe_stage;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, out_ready;
   logic [6:0]  in_ctrl;
   logic [1:0]  in_bw;
   logic        in_branch, in_zero, in_jal, in_jalr;
   logic [13:0] in_pc;
   logic [31:0] in_imm, in_alu, in_wdata;
   logic [4:0]  in_rd;

   logic        in_ready, out_valid, redirect;
   logic [6:0]  out_ctrl;
   logic [1:0]  out_bw;
   logic [31:0] out_alu, out_wdata;
   logic [4:0]  out_rd;
   logic [13:0] redirect_pc;
   logic [15:0] stall_cnt;

   logic        in_valid4, out_ready4;
   logic        in_ready4, out_valid4, redirect4;
   logic [6:0]  out_ctrl4;
   logic [1:0]  out_bw4;
   logic [31:0] out_alu4, out_wdata4;
   logic [4:0]  out_rd4;
   logic [13:0] redirect_pc4;
   logic [3:0]  stall_cnt4;

   int testsRun  = 0;
   int testsFail = 0;

   typedef struct {
      logic        v;
      logic [6:0]  ctrl;
      logic [1:0]  bw;
      logic [31:0] alu;
      logic [31:0] wdata;
      logic [4:0]  rd;
      logic        expV;
      logic [6:0]  expCtrl;
      logic [1:0]  expBw;
      logic [31:0] expAlu;
      logic [31:0] expWdata;
      logic [4:0]  expRd;
   } vec_t;

   vec_t vecs[9];

   always #5 clk = ~clk;

   ex_mem_pipe_stage dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_ctrl(in_ctrl), .in_bw(in_bw), .in_branch(in_branch), .in_zero(in_zero),
      .in_jal(in_jal), .in_jalr(in_jalr), .in_pc(in_pc), .in_imm(in_imm),
      .in_alu(in_alu), .in_wdata(in_wdata), .in_rd(in_rd),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_ctrl(out_ctrl), .out_bw(out_bw), .out_alu(out_alu),
      .out_wdata(out_wdata), .out_rd(out_rd),
      .redirect(redirect), .redirect_pc(redirect_pc), .stall_cnt(stall_cnt)
   );

   ex_mem_pipe_stage #(.CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid4), .in_ready(in_ready4),
      .in_ctrl(in_ctrl), .in_bw(in_bw), .in_branch(in_branch), .in_zero(in_zero),
      .in_jal(in_jal), .in_jalr(in_jalr), .in_pc(in_pc), .in_imm(in_imm),
      .in_alu(in_alu), .in_wdata(in_wdata), .in_rd(in_rd),
      .out_valid(out_valid4), .out_ready(out_ready4),
      .out_ctrl(out_ctrl4), .out_bw(out_bw4), .out_alu(out_alu4),
      .out_wdata(out_wdata4), .out_rd(out_rd4),
      .redirect(redirect4), .redirect_pc(redirect_pc4), .stall_cnt(stall_cnt4)
   );

   // Advance one clock and settle just after the edge, away from it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [6:0] ctrl, input logic [1:0] bw,
                                input logic [31:0] alu, input logic [31:0] wdata,
                                input logic [4:0] rd);
      in_valid  = v;
      in_ctrl   = ctrl;
      in_bw     = bw;
      in_alu    = alu;
      in_wdata  = wdata;
      in_rd     = rd;
      in_branch = 1'b0;
      in_zero   = 1'b0;
      in_jal    = 1'b0;
      in_jalr   = 1'b0;
      in_pc     = '0;
      in_imm    = '0;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   initial begin
      vecs[0] = '{1'b1, 7'h40, 2'd2, 32'h1111_1111, 32'h0000_00A0, 5'd1,
                  1'b1, 7'h40, 2'd2, 32'h1111_1111, 32'h0000_00A0, 5'd1};
      vecs[1] = '{1'b1, 7'h68, 2'd0, 32'h0000_0100, 32'h0000_00A1, 5'd2,
                  1'b1, 7'h68, 2'd0, 32'h0000_0100, 32'h0000_00A1, 5'd2};
      vecs[2] = '{1'b1, 7'h10, 2'd1, 32'h0000_0204, 32'hCAFE_BABE, 5'd0,
                  1'b1, 7'h10, 2'd1, 32'h0000_0204, 32'hCAFE_BABE, 5'd0};
      vecs[3] = '{1'b1, 7'h02, 2'd2, 32'h0000_3000, 32'h0000_0055, 5'd3,
                  1'b1, 7'h02, 2'd2, 32'h0000_3000, 32'h0000_0055, 5'd3};
      vecs[4] = '{1'b1, 7'h44, 2'd2, 32'h0000_3004, 32'h0000_0066, 5'd4,
                  1'b1, 7'h44, 2'd2, 32'h0000_3004, 32'h0000_0066, 5'd4};
      vecs[5] = '{1'b1, 7'h40, 2'd2, 32'hFFFF_FFFF, 32'h0000_0077, 5'd31,
                  1'b1, 7'h40, 2'd2, 32'hFFFF_FFFF, 32'h0000_0077, 5'd31};
      vecs[6] = '{1'b1, 7'h00, 2'd0, 32'h0000_0000, 32'h0000_0000, 5'd0,
                  1'b1, 7'h00, 2'd0, 32'h0000_0000, 32'h0000_0000, 5'd0};
      vecs[7] = '{1'b1, 7'h49, 2'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd15,
                  1'b1, 7'h49, 2'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd15};
      // Bubble: payload holds the last op, side-effect enables masked off
      vecs[8] = '{1'b0, 7'h7F, 2'd0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 5'd7,
                  1'b0, 7'h09, 2'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd15};

      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
      in_valid4 = 1'b0; out_ready4 = 1'b1;
      applyStimulus(1'b0, 7'h00, 2'd0, 32'h0, 32'h0, 5'd0);
      step();
      step();
      checkOutput("reset.out_valid", out_valid, 0);
      checkOutput("reset.in_ready", in_ready, 1);
      checkOutput("reset.out_ctrl", out_ctrl, 0);
      checkOutput("reset.out_alu", out_alu, 0);
      checkOutput("reset.redirect", redirect, 0);
      checkOutput("reset.redirect_pc", redirect_pc, 0);
      checkOutput("reset.stall_cnt", stall_cnt, 0);
      rst_n = 1'b1;

      $display("[TB] streaming vectors");
      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].v, vecs[i].ctrl, vecs[i].bw, vecs[i].alu,
                       vecs[i].wdata, vecs[i].rd);
         step();
         checkOutput($sformatf("vec%0d.out_valid", i), out_valid, vecs[i].expV);
         checkOutput($sformatf("vec%0d.out_ctrl", i), out_ctrl, vecs[i].expCtrl);
         checkOutput($sformatf("vec%0d.out_bw", i), out_bw, vecs[i].expBw);
         checkOutput($sformatf("vec%0d.out_alu", i), out_alu, vecs[i].expAlu);
         checkOutput($sformatf("vec%0d.out_wdata", i), out_wdata, vecs[i].expWdata);
         checkOutput($sformatf("vec%0d.out_rd", i), out_rd, vecs[i].expRd);
         checkOutput($sformatf("vec%0d.in_ready", i), in_ready, 1);
      end
      checkOutput("stream.stall_cnt", stall_cnt, 0);

      $display("[TB] back-pressure");
      out_ready = 1'b0;
      applyStimulus(1'b1, 7'h40, 2'd2, 32'h0000_000A, 32'h0, 5'd10);
      step();
      checkOutput("bp.first.out_alu", out_alu, 32'hA);
      checkOutput("bp.first.in_ready", in_ready, 1);
      applyStimulus(1'b1, 7'h40, 2'd2, 32'h0000_000B, 32'h0, 5'd11);
      step();
      checkOutput("bp.second.in_ready", in_ready, 0);
      checkOutput("bp.second.out_alu", out_alu, 32'hA);
      applyStimulus(1'b1, 7'h40, 2'd2, 32'h0000_000C, 32'h0, 5'd12);
      step();
      step();
      checkOutput("bp.held.stall_cnt", stall_cnt, 3);
      checkOutput("bp.held.in_ready", in_ready, 0);
      checkOutput("bp.held.out_alu", out_alu, 32'hA);
      out_ready = 1'b1;
      step();
      checkOutput("bp.rel1.out_alu", out_alu, 32'hB);
      checkOutput("bp.rel1.out_valid", out_valid, 1);
      checkOutput("bp.rel1.in_ready", in_ready, 1);
      step();
      checkOutput("bp.rel2.out_alu", out_alu, 32'hC);
      checkOutput("bp.rel2.out_valid", out_valid, 1);
      applyStimulus(1'b0, 7'h00, 2'd0, 32'h0, 32'h0, 5'd0);
      step();
      checkOutput("bp.rel3.out_valid", out_valid, 0);
      checkOutput("bp.rel3.stall_cnt", stall_cnt, 3);

      $display("[TB] branch and jump redirect");
      applyStimulus(1'b1, 7'h00, 2'd0, 32'h0, 32'h0, 5'd0);
      in_branch = 1'b1; in_zero = 1'b1; in_pc = 14'h0100; in_imm = 32'h20;
      step();
      checkOutput("beq.taken.redirect", redirect, 1);
      checkOutput("beq.taken.redirect_pc", redirect_pc, 14'h0120);
      in_zero = 1'b0; in_imm = 32'h40;
      step();
      checkOutput("beq.nottaken.redirect", redirect, 0);
      checkOutput("beq.nottaken.redirect_pc", redirect_pc, 14'h0120);
      applyStimulus(1'b1, 7'h40, 2'd0, 32'h0000_3FFF, 32'h0, 5'd1);
      in_jalr = 1'b1;
      step();
      checkOutput("jalr.redirect", redirect, 1);
      checkOutput("jalr.redirect_pc", redirect_pc, 14'h3FFE);
      applyStimulus(1'b1, 7'h40, 2'd0, 32'h0, 32'h0, 5'd1);
      in_jal = 1'b1; in_pc = 14'h3FF0; in_imm = 32'h20;
      step();
      checkOutput("jal.wrap.redirect", redirect, 1);
      checkOutput("jal.wrap.redirect_pc", redirect_pc, 14'h0010);
      applyStimulus(1'b0, 7'h00, 2'd0, 32'h0, 32'h0, 5'd0);
      step();
      checkOutput("jump.pulse.redirect", redirect, 0);
      checkOutput("jump.pulse.out_valid", out_valid, 0);

      $display("[TB] flush with both entries full");
      out_ready = 1'b0;
      applyStimulus(1'b1, 7'h40, 2'd2, 32'h0000_000D, 32'h0, 5'd13);
      step();
      applyStimulus(1'b1, 7'h50, 2'd2, 32'h0000_000E, 32'h0, 5'd14);
      in_jal = 1'b1; in_pc = 14'h0200; in_imm = 32'h10;
      step();
      checkOutput("stalljump.redirect", redirect, 1);
      checkOutput("stalljump.redirect_pc", redirect_pc, 14'h0210);
      checkOutput("stalljump.in_ready", in_ready, 0);
      applyStimulus(1'b1, 7'h40, 2'd2, 32'h0000_000F, 32'h0, 5'd15);
      in_jal = 1'b1; in_pc = 14'h0300; in_imm = 32'h4;
      flush = 1'b1;
      step();
      checkOutput("flush.out_valid", out_valid, 0);
      checkOutput("flush.out_ctrl", out_ctrl, 7'h00);
      checkOutput("flush.in_ready", in_ready, 1);
      checkOutput("flush.redirect", redirect, 0);
      checkOutput("flush.stall_cnt", stall_cnt, 4);
      flush = 1'b0;
      applyStimulus(1'b0, 7'h00, 2'd0, 32'h0, 32'h0, 5'd0);
      step();
      checkOutput("postflush.out_valid", out_valid, 0);
      checkOutput("postflush.redirect_pc", redirect_pc, 14'h0210);

      $display("[TB] reset mid-stall");
      applyStimulus(1'b1, 7'h40, 2'd2, 32'h0000_0077, 32'h0, 5'd7);
      step();
      applyStimulus(1'b0, 7'h00, 2'd0, 32'h0, 32'h0, 5'd0);
      step();
      checkOutput("midstall.stall_cnt", stall_cnt, 5);
      rst_n = 1'b0;
      step();
      checkOutput("midreset.out_valid", out_valid, 0);
      checkOutput("midreset.out_alu", out_alu, 0);
      checkOutput("midreset.out_ctrl", out_ctrl, 0);
      checkOutput("midreset.redirect_pc", redirect_pc, 0);
      checkOutput("midreset.stall_cnt", stall_cnt, 0);
      checkOutput("midreset.in_ready", in_ready, 1);
      rst_n = 1'b1;

      $display("[TB] narrow counter saturation");
      out_ready4 = 1'b0;
      applyStimulus(1'b0, 7'h40, 2'd2, 32'h0000_0042, 32'h0, 5'd2);
      in_valid4 = 1'b1;
      step();
      in_valid4 = 1'b0;
      for (int i = 0; i < 14; i++) step();
      checkOutput("cnt4.at14", stall_cnt4, 14);
      for (int i = 0; i < 6; i++) step();
      checkOutput("cnt4.saturated", stall_cnt4, 15);
      checkOutput("cnt4.out_alu", out_alu4, 32'h42);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
      $finish;
   end

endmodule
